// File: rtl/his_ram_scheduler.sv
// rtl/his_ram_scheduler.sv - frame sequencer and sole owner of the SiFH histogram SRAM
// Optional feature macro: SIFH_SCAN_CLEAR_EN (peak scan zeroes bins, CLEAR skipped after first frame)
module his_ram_scheduler #(
  parameter int NB       = 6,
  parameter int PIX_BITS = 2,
  parameter int CNT_W    = 8,
  parameter int ACQ_NUM  = 1024
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     start,
  input  logic                     stampValid,
  output logic                     stampReady,
  input  logic [PIX_BITS-1:0]      stampPix,
  input  logic [NB-1:0]            stampBin,
  output logic [PIX_BITS+NB-1:0]   waddr,
  output logic                     wEnable,
  output logic [CNT_W-1:0]         newCounts,
  output logic [PIX_BITS+NB-1:0]   raddr,
  output logic                     rEnable,
  input  logic [CNT_W-1:0]         counts,
  output logic                     peakValid,
  input  logic                     peakReady,
  output logic [PIX_BITS-1:0]      peakPix,
  output logic [NB-1:0]            peakBin,
  output logic [CNT_W-1:0]         peakCount,
  output logic                     busy,
  output logic                     hisBuildDone
);

  localparam int AW    = PIX_BITS + NB;
  localparam int ACC_W = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1;
  localparam logic [ACC_W-1:0] ACC_LAST = ACC_W'(ACQ_NUM - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [NB-1:0]    BIN_LAST = '1;
  localparam logic [PIX_BITS-1:0] PIX_LAST = '1;
  localparam logic [AW-1:0]    ADDR_LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ACQ, S_DRAIN, S_PEAK, S_OUT, S_DONE
  } state_t;

  state_t               state_q;
  logic                 drain_q;
  logic [ACC_W-1:0]     acc_q;
  logic [PIX_BITS-1:0]  pix_q;
  logic [NB-1:0]        bin_q;
  logic                 issue_q;
  logic [CNT_W-1:0]     max_cnt_q;
  logic [NB-1:0]        max_bin_q;
  logic                 s1_vld_q, s2_vld_q, w2_vld_q;
  logic [AW-1:0]        s1_addr_q, s2_addr_q, w2_addr_q;
  logic [CNT_W-1:0]     w2_data_q;
  logic                 rd1_vld_q, rd2_vld_q;
  logic [NB-1:0]        rd1_bin_q, rd2_bin_q;
  logic                 stamp_ready_q, wen_q, ren_q, peak_valid_q, busy_q, done_q;
  logic [AW-1:0]        waddr_q, raddr_q;
  logic [CNT_W-1:0]     new_cnt_q, peak_cnt_q;
  logic [PIX_BITS-1:0]  peak_pix_q;
  logic [NB-1:0]        peak_bin_q;
`ifdef SIFH_SCAN_CLEAR_EN
  logic                 cleared_q;
`endif

  logic [CNT_W-1:0]     fwd_d, inc_d, scan_cnt_d;
  logic [NB-1:0]        scan_bin_d;
  logic                 cmp_gt;

  // The write on port a right now is newer than the one that committed on the
  // edge our read was sampled, so it takes priority.
  always_comb begin
    fwd_d = counts;
    if (w2_vld_q && (w2_addr_q == s2_addr_q)) fwd_d = w2_data_q;
    if (wen_q && (waddr_q == s2_addr_q))      fwd_d = new_cnt_q;
    inc_d = (fwd_d == CNT_MAX) ? CNT_MAX : fwd_d + CNT_W'(1);
    cmp_gt     = counts > max_cnt_q;
    scan_cnt_d = cmp_gt ? counts : max_cnt_q;
    scan_bin_d = cmp_gt ? rd2_bin_q : max_bin_q;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q       <= S_IDLE;
      drain_q       <= 1'b0;
      acc_q         <= '0;
      pix_q         <= '0;
      bin_q         <= '0;
      issue_q       <= 1'b0;
      max_cnt_q     <= '0;
      max_bin_q     <= '0;
      s1_vld_q      <= 1'b0;
      s2_vld_q      <= 1'b0;
      w2_vld_q      <= 1'b0;
      s1_addr_q     <= '0;
      s2_addr_q     <= '0;
      w2_addr_q     <= '0;
      w2_data_q     <= '0;
      rd1_vld_q     <= 1'b0;
      rd2_vld_q     <= 1'b0;
      rd1_bin_q     <= '0;
      rd2_bin_q     <= '0;
      stamp_ready_q <= 1'b0;
      wen_q         <= 1'b0;
      ren_q         <= 1'b0;
      peak_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      waddr_q       <= '0;
      raddr_q       <= '0;
      new_cnt_q     <= '0;
      peak_cnt_q    <= '0;
      peak_pix_q    <= '0;
      peak_bin_q    <= '0;
`ifdef SIFH_SCAN_CLEAR_EN
      cleared_q     <= 1'b0;
`endif
    end else begin
      wen_q     <= 1'b0;
      ren_q     <= 1'b0;
      done_q    <= 1'b0;
      s1_vld_q  <= 1'b0;
      s2_vld_q  <= s1_vld_q;
      s2_addr_q <= s1_addr_q;
      w2_vld_q  <= wen_q;
      w2_addr_q <= waddr_q;
      w2_data_q <= new_cnt_q;
      rd1_vld_q <= 1'b0;
      rd2_vld_q <= rd1_vld_q;
      rd2_bin_q <= rd1_bin_q;

      // Stamp write-back stage runs in any state so DRAIN can flush it.
      if (s2_vld_q) begin
        wen_q     <= 1'b1;
        waddr_q   <= s2_addr_q;
        new_cnt_q <= inc_d;
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
`ifdef SIFH_SCAN_CLEAR_EN
            if (cleared_q) begin
              state_q       <= S_ACQ;
              stamp_ready_q <= 1'b1;
              acc_q         <= '0;
            end else begin
              state_q   <= S_CLEAR;
              wen_q     <= 1'b1;
              waddr_q   <= '0;
              new_cnt_q <= '0;
            end
`else
            state_q   <= S_CLEAR;
            wen_q     <= 1'b1;
            waddr_q   <= '0;
            new_cnt_q <= '0;
`endif
          end
        end
        S_CLEAR: begin
          if (waddr_q == ADDR_LAST) begin
            state_q       <= S_ACQ;
            stamp_ready_q <= 1'b1;
            acc_q         <= '0;
          end else begin
            wen_q     <= 1'b1;
            waddr_q   <= waddr_q + AW'(1);
            new_cnt_q <= '0;
          end
        end
        S_ACQ: begin
          if (stampValid && stamp_ready_q) begin
            s1_vld_q  <= 1'b1;
            s1_addr_q <= {stampPix, stampBin};
            raddr_q   <= {stampPix, stampBin};
            ren_q     <= 1'b1;
            if (acc_q == ACC_LAST) begin
              stamp_ready_q <= 1'b0;
              state_q       <= S_DRAIN;
              drain_q       <= 1'b0;
            end else begin
              acc_q <= acc_q + ACC_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (drain_q) begin
            state_q   <= S_PEAK;
            pix_q     <= '0;
            bin_q     <= '0;
            issue_q   <= 1'b1;
            max_cnt_q <= '0;
            max_bin_q <= '0;
          end else begin
            drain_q <= 1'b1;
          end
        end
        S_PEAK: begin
          if (issue_q) begin
            raddr_q   <= {pix_q, bin_q};
            ren_q     <= 1'b1;
            rd1_vld_q <= 1'b1;
            rd1_bin_q <= bin_q;
            if (bin_q == BIN_LAST) issue_q <= 1'b0;
            else                   bin_q   <= bin_q + NB'(1);
          end
          if (rd2_vld_q) begin
            max_cnt_q <= scan_cnt_d;
            max_bin_q <= scan_bin_d;
`ifdef SIFH_SCAN_CLEAR_EN
            wen_q     <= 1'b1;
            waddr_q   <= {pix_q, rd2_bin_q};
            new_cnt_q <= '0;
`endif
            if (rd2_bin_q == BIN_LAST) begin
              state_q      <= S_OUT;
              peak_valid_q <= 1'b1;
              peak_pix_q   <= pix_q;
              peak_bin_q   <= scan_bin_d;
              peak_cnt_q   <= scan_cnt_d;
            end
          end
        end
        S_OUT: begin
          if (peakReady) begin
            peak_valid_q <= 1'b0;
            if (pix_q == PIX_LAST) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= S_PEAK;
              pix_q     <= pix_q + PIX_BITS'(1);
              bin_q     <= '0;
              issue_q   <= 1'b1;
              max_cnt_q <= '0;
              max_bin_q <= '0;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
`ifdef SIFH_SCAN_CLEAR_EN
          cleared_q <= 1'b1;
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stampReady   = stamp_ready_q;
  assign waddr        = waddr_q;
  assign wEnable      = wen_q;
  assign newCounts    = new_cnt_q;
  assign raddr        = raddr_q;
  assign rEnable      = ren_q;
  assign peakValid    = peak_valid_q;
  assign peakPix      = peak_pix_q;
  assign peakBin      = peak_bin_q;
  assign peakCount    = peak_cnt_q;
  assign busy         = busy_q;
  assign hisBuildDone = done_q;

endmodule

// File: tb/tb_his_ram_scheduler.sv
// tb/tb_his_ram_scheduler.sv - scoreboard bench for his_ram_scheduler with a behavioural dual-port RAM
module tb_his_ram_scheduler;
  localparam int NB = 6, PB = 2, CW = 2, AN = 8, AW = 8;
`ifdef SIFH_SCAN_CLEAR_EN
  localparam int F2_CYC = 1, F2_CLR = 0, PEAK_WR = 256;
`else
  localparam int F2_CYC = 257, F2_CLR = 256, PEAK_WR = 0;
`endif

  logic clk = 1'b0, res = 1'b1, start = 1'b0, stampValid = 1'b0, peakReady = 1'b0;
  logic [PB-1:0] stampPix = '0;
  logic [NB-1:0] stampBin = '0;
  logic [CW-1:0] counts = '0;
  logic stampReady, wEnable, rEnable, peakValid, busy, hisBuildDone;
  logic [AW-1:0] waddr, raddr;
  logic [CW-1:0] newCounts, peakCount;
  logic [PB-1:0] peakPix;
  logic [NB-1:0] peakBin;

  his_ram_scheduler #(.NB(NB), .PIX_BITS(PB), .CNT_W(CW), .ACQ_NUM(AN)) dut (
    .clk(clk), .res(res), .start(start), .stampValid(stampValid), .stampReady(stampReady),
    .stampPix(stampPix), .stampBin(stampBin), .waddr(waddr), .wEnable(wEnable),
    .newCounts(newCounts), .raddr(raddr), .rEnable(rEnable), .counts(counts),
    .peakValid(peakValid), .peakReady(peakReady), .peakPix(peakPix), .peakBin(peakBin),
    .peakCount(peakCount), .busy(busy), .hisBuildDone(hisBuildDone)
  );

  always #5 clk = ~clk;

  logic [CW-1:0] ram [256];
  always @(posedge clk) begin
    if (wEnable) ram[waddr] <= newCounts;
    if (rEnable) counts <= ram[raddr];
  end

  typedef struct packed { logic [AW-1:0] a; logic [CW-1:0] d; } wr_t;
  wr_t exp_q[$];
  int model [256];
  int sp [AN], sb [AN], sg [AN];
  int total = 0, bad = 0;
  int mode = 0, clear_cnt = 0, peak_wr_cnt = 0, hs_cnt = 0, done_cnt = 0;

  // mode: 0 idle (no writes allowed), 1 clear, 2 acquisition, 3 peak scan, 4 ignore
  always @(negedge clk) begin
    if (wEnable) begin
      case (mode)
        1: begin
          total++;
          if (waddr !== AW'(clear_cnt) || newCounts !== '0) begin
            bad++;
            $display("FAIL clear_write: got addr=%0d data=%0d, want addr=%0d data=0", waddr, newCounts, clear_cnt);
          end
          clear_cnt++;
        end
        2: begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL acq_write_unexpected: got addr=%0d data=%0d, want no write", waddr, newCounts);
          end else begin
            wr_t e;
            e = exp_q.pop_front();
            if (waddr !== e.a || newCounts !== e.d) begin
              bad++;
              $display("FAIL acq_write: got addr=%0d data=%0d, want addr=%0d data=%0d", waddr, newCounts, e.a, e.d);
            end
          end
        end
        3: begin
          peak_wr_cnt++;
          total++;
          if (newCounts !== '0) begin
            bad++;
            $display("FAIL scan_clear_data: got %0d, want 0", newCounts);
          end
        end
        0: begin
          total++; bad++;
          $display("FAIL stray_write: got addr=%0d, want no write", waddr);
        end
        default: ;
      endcase
    end
    if (peakValid && peakReady) hs_cnt++;
    if (hisBuildDone) done_cnt++;
  end

  task automatic randomize_ram();
    for (int i = 0; i < 256; i++) ram[i] = CW'($urandom);
  endtask

  task automatic load_a();
    int p [AN] = '{1, 1, 1, 2, 2, 2, 2, 3};
    int b [AN] = '{5, 5, 5, 10, 10, 40, 40, 63};
    for (int i = 0; i < AN; i++) begin sp[i] = p[i]; sb[i] = b[i]; sg[i] = 0; end
  endtask

  task automatic load_b();
    int p [AN] = '{0, 0, 0, 0, 0, 3, 3, 1};
    int b [AN] = '{0, 0, 0, 0, 0, 7, 7, 0};
    int g [AN] = '{0, 0, 2, 1, 0, 3, 0, 0};
    for (int i = 0; i < AN; i++) begin sp[i] = p[i]; sb[i] = b[i]; sg[i] = g[i]; end
  endtask

  task automatic do_start(input int exp_cyc, input int exp_clr);
    int cyc;
    for (int i = 0; i < 256; i++) model[i] = 0;
    clear_cnt = 0;
    @(posedge clk); #1; start = 1'b1; mode = 1;
    @(posedge clk); #1; start = 1'b0;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!stampReady && cyc < 400);
    total++;
    if (cyc != exp_cyc) begin bad++; $display("FAIL clear_len: got %0d cycles to stampReady, want %0d", cyc, exp_cyc); end
    total++;
    if (clear_cnt != exp_clr) begin bad++; $display("FAIL clear_count: got %0d writes, want %0d", clear_cnt, exp_clr); end
    mode = 2;
  endtask

  task automatic send_stamps();
    logic rdy;
    int g, nv;
    logic [AW-1:0] a;
    @(posedge clk); #1;
    for (int i = 0; i < AN; i++) begin
      stampValid = 1'b0;
      repeat (sg[i]) begin @(posedge clk); #1; end
      stampValid = 1'b1; stampPix = PB'(sp[i]); stampBin = NB'(sb[i]);
      g = 0;
      do begin @(negedge clk); rdy = stampReady; @(posedge clk); g++; end while (!rdy && g < 20);
      #1;
      if (!rdy) begin
        total++; bad++;
        $display("FAIL accept_timeout: got stampReady=0, want 1 (stamp %0d)", i);
      end else begin
        a = {stampPix, stampBin};
        nv = (model[a] >= 3) ? 3 : model[a] + 1;
        model[a] = nv;
        exp_q.push_back('{a: a, d: CW'(nv)});
      end
    end
    stampValid = 1'b0;
    @(negedge clk);
    total++;
    if (stampReady !== 1'b0) begin bad++; $display("FAIL ready_drop: got %0b, want 0", stampReady); end
    g = 0;
    while (exp_q.size() != 0 && g < 20) begin @(posedge clk); g++; end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL drain: got %0d writes pending, want 0", exp_q.size()); end
    exp_q.delete();
    mode = 3; peak_wr_cnt = 0; hs_cnt = 0; done_cnt = 0;
  endtask

  task automatic recv_peaks(input int stall_p, input bit pulse_start);
    int ebin [4], ecnt [4], g;
    for (int p = 0; p < 4; p++) begin
      ebin[p] = 0; ecnt[p] = 0;
      for (int b = 0; b < 64; b++)
        if (model[p*64+b] > ecnt[p]) begin ecnt[p] = model[p*64+b]; ebin[p] = b; end
    end
    if (pulse_start) begin
      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
    end
    for (int p = 0; p < 4; p++) begin
      g = 0;
      do begin @(negedge clk); g++; end while (!peakValid && g < 300);
      total++;
      if (!peakValid) begin
        bad++; $display("FAIL peak_timeout: got peakValid=0, want 1 (pixel %0d)", p);
      end else if (peakPix !== PB'(p) || peakBin !== NB'(ebin[p]) || peakCount !== CW'(ecnt[p])) begin
        bad++;
        $display("FAIL peak_data: got pix=%0d bin=%0d cnt=%0d, want pix=%0d bin=%0d cnt=%0d",
                 peakPix, peakBin, peakCount, p, ebin[p], ecnt[p]);
      end
      if (p == stall_p) begin
        repeat (7) begin
          @(negedge clk);
          total++;
          if (peakValid !== 1'b1 || peakPix !== PB'(p) || peakBin !== NB'(ebin[p]) || peakCount !== CW'(ecnt[p])) begin
            bad++;
            $display("FAIL peak_hold: got v=%0b pix=%0d bin=%0d cnt=%0d, want v=1 pix=%0d bin=%0d cnt=%0d",
                     peakValid, peakPix, peakBin, peakCount, p, ebin[p], ecnt[p]);
          end
        end
      end
      @(posedge clk); #1; peakReady = 1'b1;
      @(posedge clk); #1; peakReady = 1'b0;
    end
    g = 0;
    do begin @(negedge clk); g++; end while (busy && g < 50);
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || peakValid !== 1'b0) begin bad++; $display("FAIL end_idle: got busy=%0b peakValid=%0b, want 0 0", busy, peakValid); end
    total++;
    if (done_cnt != 1) begin bad++; $display("FAIL done_pulse: got %0d pulses, want 1", done_cnt); end
    total++;
    if (hs_cnt != 4) begin bad++; $display("FAIL handshakes: got %0d, want 4", hs_cnt); end
    total++;
    if (peak_wr_cnt != PEAK_WR) begin bad++; $display("FAIL scan_writes: got %0d, want %0d", peak_wr_cnt, PEAK_WR); end
    mode = 0;
  endtask

  task automatic test_reset();
    res = 1'b1;
    repeat (3) @(posedge clk);
    #1; res = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if ({stampReady, waddr, wEnable, newCounts, raddr, rEnable, peakValid, peakPix,
           peakBin, peakCount, busy, hisBuildDone} !== '0) begin
        bad++; $display("FAIL reset_outputs: got nonzero output at idle cycle %0d, want all 0", i);
      end
    end
  endtask

  task automatic test_frame_a(input int exp_cyc, input int exp_clr, input int stall_p);
    load_a();
    do_start(exp_cyc, exp_clr);
    send_stamps();
    recv_peaks(stall_p, 1'b1);
  endtask

  task automatic test_saturate_gaps();
    load_b();
    do_start(F2_CYC, F2_CLR);
    send_stamps();
    recv_peaks(3, 1'b0);
  endtask

  task automatic test_mid_reset();
    do_start(F2_CYC, F2_CLR);
    mode = 4;
    @(posedge clk); #1;
    stampValid = 1'b1; stampPix = 2'd2; stampBin = 6'd2;
    @(posedge clk); #1;
    @(posedge clk); #1;
    res = 1'b1; stampValid = 1'b0;
    @(posedge clk); #1; res = 1'b0;
    @(negedge clk);
    total++;
    if ({stampReady, waddr, wEnable, newCounts, raddr, rEnable, peakValid, peakPix,
         peakBin, peakCount, busy, hisBuildDone} !== '0) begin
      bad++; $display("FAIL mid_reset_outputs: got nonzero output after reset, want all 0");
    end
    mode = 0;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || stampReady !== 1'b0) begin bad++; $display("FAIL mid_reset_idle: got busy=%0b ready=%0b, want 0 0", busy, stampReady); end
    randomize_ram();
  endtask

  initial begin
    randomize_ram();
    test_reset();
    test_frame_a(257, 256, 1);
    test_saturate_gaps();
    test_mid_reset();
    test_frame_a(257, 256, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
